muldiv_iter_unit: RTL and testbench

//  Parametrised iterative RV32M/RV64M multiply/divide engine for the multicycle datapath; replaces separate multiplier/divider pair.

---
 rtl/muldiv_iter_unit.sv | 217 +++++++++++++++++++++
 tb/tb_muldiv_iter_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter_unit.sv
// -----------------------------------------------------------------------------
// muldiv_iter_unit
//   Shared iterative RV32M/RV64M multiply/divide engine. One request at a time:
//   the operands are latched in IDLE, turned into magnitudes in PREP, and then
//   processed with a shift-add multiply (MUL_STEP bits per cycle) or a restoring
//   divide (1 bit per cycle). FIX applies the sign and picks the result half.
//   DONE pulses ready for one cycle. A divide by zero and the signed overflow
//   case finish straight from PREP.
//
//   Optional build macro:
//     MULDIV_FAST_MUL_EN - multiplies use one combinational 2*XLEN product
//                          that is registered in PREP. They finish from PREP
//                          and skip CALC/FIX. Divides are unaffected.
//
// Parameters
//   XLEN      operand/result width (32 or 64)
//   MUL_STEP  multiplier bits retired per CALC cycle (1, 2 or 4, divides XLEN)
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   valid        in   request, held until ready
//   op           in   funct3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   rs1          in   multiplicand / dividend
//   rs2          in   multiplier / divisor
//   flush        in   abort the current operation
//   ready        out  one-cycle completion pulse
//   result       out  result, held until the next acceptance
//   busy         out  high in every state except IDLE
//   div_by_zero  out  divide with rs2 == 0, valid together with ready
// -----------------------------------------------------------------------------
module muldiv_iter_unit #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            div_by_zero
);

  localparam int MUL_K = XLEN / MUL_STEP;
  localparam int CW    = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   rs1_q, rs2_q;
  logic [XLEN-1:0]   opa_q;       // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q;       // mul: {partial hi, multiplier lo}; div: {remainder, quotient}
  logic              neg_q;       // result must be negated in FIX
  logic [CW-1:0]     cnt_q;
  logic              ready_q, busy_q, dbz_q;
  logic [XLEN-1:0]   result_q;

  // ---------------- operand decode (from latched request) ----------------
  logic            is_div, is_rem, a_signed, b_signed, a_neg, b_neg;
  logic            res_neg_d, div_zero_d, div_ovf_d;
  logic [XLEN-1:0] abs_a_d, abs_b_d;

  assign is_div     = op_q[2];
  assign is_rem     = op_q[2] & op_q[1];
  assign a_signed   = op_q[2] ? ~op_q[0] : (op_q[1:0] == 2'd1 || op_q[1:0] == 2'd2);
  assign b_signed   = op_q[2] ? ~op_q[0] : (op_q[1:0] == 2'd1);
  assign a_neg      = a_signed & rs1_q[XLEN-1];
  assign b_neg      = b_signed & rs2_q[XLEN-1];
  assign abs_a_d    = a_neg ? -rs1_q : rs1_q;
  assign abs_b_d    = b_neg ? -rs2_q : rs2_q;
  // Remainder sign follows the dividend only; everything else is sign XOR.
  assign res_neg_d  = a_neg ^ (b_neg & ~is_rem);
  assign div_zero_d = is_div && (rs2_q == '0);
  assign div_ovf_d  = is_div && !op_q[0] && (rs1_q == MIN_NEG) && (rs2_q == '1);

  // ---------------- shift-add multiply step ----------------
  logic [XLEN+MUL_STEP-1:0] pp_term [MUL_STEP];
  logic [XLEN+MUL_STEP-1:0] pp_sum_d, msum_d;
  logic [2*XLEN-1:0]        mul_acc_d;

  for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_pp
    assign pp_term[gi] = acc_q[gi] ? ({{MUL_STEP{1'b0}}, opa_q} << gi) : '0;
  end

  always_comb begin
    pp_sum_d = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      pp_sum_d = pp_sum_d + pp_term[j];
    end
    msum_d = {{MUL_STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]} + pp_sum_d;
  end

  // Retire the consumed multiplier bits off the bottom while the sum shifts in.
  assign mul_acc_d = {msum_d, acc_q[XLEN-1:MUL_STEP]};

  // ---------------- restoring divide step ----------------
  logic [XLEN:0]     rshift_d, rdiff_d;
  logic [2*XLEN-1:0] div_acc_d;

  assign rshift_d  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign rdiff_d   = rshift_d - {1'b0, opa_q};
  assign div_acc_d = rdiff_d[XLEN] ? {rshift_d[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {rdiff_d[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

  // ---------------- sign fix and result select ----------------
  logic [2*XLEN-1:0] prod_fix_d;
  logic [XLEN-1:0]   quot_fix_d, rem_fix_d, fix_result_d;

  assign prod_fix_d = neg_q ? -acc_q : acc_q;
  assign quot_fix_d = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix_d  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  assign fix_result_d = is_div ? (op_q[1] ? rem_fix_d : quot_fix_d)
                               : ((op_q[1:0] == 2'd0) ? prod_fix_d[XLEN-1:0]
                                                      : prod_fix_d[2*XLEN-1:XLEN]);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a_d, fast_b_d, fast_prod_d;
  logic [XLEN-1:0]   fast_result_d;

  assign fast_a_d      = {{XLEN{a_neg}}, rs1_q};
  assign fast_b_d      = {{XLEN{b_neg}}, rs2_q};
  assign fast_prod_d   = fast_a_d * fast_b_d;
  assign fast_result_d = (op_q[1:0] == 2'd0) ? fast_prod_d[XLEN-1:0]
                                             : fast_prod_d[2*XLEN-1:XLEN];
`endif

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      opa_q    <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (valid) begin
            op_q    <= op;
            rs1_q   <= rs1;
            rs2_q   <= rs2;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          neg_q <= res_neg_d;
          if (div_zero_d) begin
            result_q <= op_q[1] ? rs1_q : '1;
            dbz_q    <= 1'b1;
            ready_q  <= 1'b1;
            state_q  <= S_DONE;
          end else if (div_ovf_d) begin
            result_q <= op_q[1] ? '0 : rs1_q;
            ready_q  <= 1'b1;
            state_q  <= S_DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!is_div) begin
            result_q <= fast_result_d;
            ready_q  <= 1'b1;
            state_q  <= S_DONE;
`endif
          end else begin
            opa_q   <= is_div ? abs_b_d : abs_a_d;
            acc_q   <= {{XLEN{1'b0}}, (is_div ? abs_a_d : abs_b_d)};
            cnt_q   <= is_div ? CW'(XLEN - 1) : CW'(MUL_K - 1);
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          acc_q <= is_div ? div_acc_d : mul_acc_d;
          if (cnt_q == '0) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_FIX: begin
          result_q <= fix_result_d;
          ready_q  <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready       = ready_q;
  assign result      = result_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_iter_unit
//   Drives directed and random requests into muldiv_iter_unit. A behavioural
//   model (plain SystemVerilog arithmetic) gives each request's result,
//   div_by_zero flag and ready cycle. One negedge process compares busy, ready,
//   result and div_by_zero against those expectations on every cycle.
// -----------------------------------------------------------------------------
module tb_muldiv_iter_unit;

  localparam int XLEN = 32;
  parameter  int MUL_STEP = 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            valid = 1'b0;
  logic [2:0]      op = '0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic            flush = 1'b0;
  logic            ready;
  logic [XLEN-1:0] result;
  logic            busy;
  logic            div_by_zero;

  muldiv_iter_unit #(.XLEN(XLEN), .MUL_STEP(MUL_STEP)) dut (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .ready(ready), .result(result), .busy(busy),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  // Expectations for the op in flight (written by the stimulus process only).
  bit              exp_active = 1'b0;
  int              exp_start = 0;
  int              exp_lat = 0;
  logic [XLEN-1:0] exp_res = '0;
  logic            exp_dbz = 1'b0;

  // Written by the compare process only.
  logic [XLEN-1:0] held_res = '0;
  int              checks = 0;
  int              passes = 0;
  bit              pinned = 1'b0;

  // ---------------- reference model ----------------
  function automatic void model(input logic [2:0] o, input logic [XLEN-1:0] a,
                                input logic [XLEN-1:0] b, output logic [XLEN-1:0] r,
                                output logic z, output int lat);
    logic [2*XLEN-1:0]        sa, sb, ua, ub, p;
    logic signed [XLEN-1:0]   as_s, bs_s;
    sa = {{XLEN{a[XLEN-1]}}, a};
    sb = {{XLEN{b[XLEN-1]}}, b};
    ua = {{XLEN{1'b0}}, a};
    ub = {{XLEN{1'b0}}, b};
    as_s = a;
    bs_s = b;
    z = 1'b0;
    r = '0;
`ifdef MULDIV_FAST_MUL_EN
    lat = 2;
`else
    lat = XLEN / MUL_STEP + 3;
`endif
    case (o)
      3'd0: begin p = ua * ub; r = p[XLEN-1:0]; end
      3'd1: begin p = sa * sb; r = p[2*XLEN-1:XLEN]; end
      3'd2: begin p = sa * ub; r = p[2*XLEN-1:XLEN]; end
      3'd3: begin p = ua * ub; r = p[2*XLEN-1:XLEN]; end
      default: begin
        if (b == '0) begin
          z = 1'b1;
          r = (o[1] == 1'b0) ? '1 : a;
          lat = 2;
        end else if (o[0] == 1'b0 && a == MIN_NEG && b == '1) begin
          r = (o[1] == 1'b0) ? a : '0;
          lat = 2;
        end else begin
          lat = XLEN + 3;
          case (o)
            3'd4:    r = as_s / bs_s;
            3'd5:    r = a / b;
            3'd6:    r = as_s % bs_s;
            default: r = a % b;
          endcase
        end
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
  endtask

  // Hand-computed values pinning the model itself.
  task automatic pin_model();
    logic [XLEN-1:0] r;
    logic z;
    int l;
    model(3'd0, 32'd7, 32'hFFFFFFFD, r, z, l); check("pin_mul", r, 32'hFFFFFFEB);
    model(3'd1, MIN_NEG, MIN_NEG, r, z, l);    check("pin_mulh", r, 32'h40000000);
    model(3'd3, '1, '1, r, z, l);              check("pin_mulhu", r, 32'hFFFFFFFE);
    model(3'd2, '1, '1, r, z, l);              check("pin_mulhsu", r, 32'hFFFFFFFF);
    model(3'd4, 32'hFFFFFFF9, 32'd2, r, z, l); check("pin_div", r, 32'hFFFFFFFD);
    check("pin_div_lat", l, 35);
    model(3'd6, 32'hFFFFFFF9, 32'd2, r, z, l); check("pin_rem", r, 32'hFFFFFFFF);
    model(3'd5, 32'd100, 32'd7, r, z, l);      check("pin_divu", r, 32'd14);
    model(3'd4, 32'd5, 32'd0, r, z, l);        check("pin_div0", {r, 7'd0, z}, {32'hFFFFFFFF, 8'd1});
    check("pin_div0_lat", l, 2);
    model(3'd7, 32'd5, 32'd0, r, z, l);        check("pin_remu0", r, 32'd5);
    model(3'd4, MIN_NEG, '1, r, z, l);         check("pin_div_ovf", r, 32'h80000000);
    model(3'd6, MIN_NEG, '1, r, z, l);         check("pin_rem_ovf", r, 32'd0);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    int c;
    if (!pinned) begin
      pin_model();
      pinned = 1'b1;
    end
    if (reset) begin
      check("rst_busy", busy, 1'b0);
      check("rst_ready", ready, 1'b0);
      check("rst_result", result, '0);
      check("rst_dbz", div_by_zero, 1'b0);
      held_res = '0;
    end else if (exp_active) begin
      c = cyc_cnt - exp_start;
      check("busy", busy, (c >= 1 && c <= exp_lat));
      check("ready", ready, (c == exp_lat));
      if (c == exp_lat) begin
        check("result", result, exp_res);
        check("dbz", div_by_zero, exp_dbz);
        held_res = exp_res;
      end
    end else begin
      check("idle_busy", busy, 1'b0);
      check("idle_ready", ready, 1'b0);
      check("idle_result", result, held_res);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // Called at posedge+2 of the acceptance cycle; returns at posedge+2 of the
  // cycle after ready. Inputs are scrambled while busy to prove they are ignored.
  task automatic issue(input logic [2:0] o, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input bit keep);
    logic [XLEN-1:0] r;
    logic z;
    int lat;
    model(o, a, b, r, z, lat);
    valid = 1'b1; op = o; rs1 = a; rs2 = b;
    exp_res = r; exp_dbz = z; exp_lat = lat; exp_start = cyc_cnt; exp_active = 1'b1;
    for (int i = 0; i <= lat; i++) begin
      @(posedge clk); #2;
      if (i < lat) begin
        op = 3'($urandom); rs1 = XLEN'($urandom); rs2 = XLEN'($urandom);
      end
    end
    if (!keep) begin
      valid = 1'b0;
      exp_active = 1'b0;
    end
  endtask

  // Start an op and abort it at cycle 'at' with flush or reset.
  task automatic abort_op(input logic [2:0] o, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input int at, input bit use_reset);
    logic [XLEN-1:0] r;
    logic z;
    int lat;
    model(o, a, b, r, z, lat);
    valid = 1'b1; op = o; rs1 = a; rs2 = b;
    exp_res = r; exp_dbz = z; exp_lat = lat; exp_start = cyc_cnt; exp_active = 1'b1;
    repeat (at) begin @(posedge clk); #2; end
    if (use_reset) begin
      reset = 1'b1; valid = 1'b0; exp_active = 1'b0;
    end else begin
      flush = 1'b1;
    end
    @(posedge clk); #2;
    reset = 1'b0; flush = 1'b0; valid = 1'b0; exp_active = 1'b0;
  endtask

  function automatic logic [XLEN-1:0] rnd_opnd();
    logic [XLEN-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = MIN_NEG;
      3:       v = XLEN'($urandom_range(0, 15));
      4:       v = ~XLEN'($urandom_range(0, 15));
      default: v = XLEN'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    logic [2:0]      o;
    logic [XLEN-1:0] a, b;
    bit              gap;

    idle(3);
    reset = 1'b0;
    idle(2);

    // Directed cases, some back-to-back with valid held through DONE.
    issue(3'd0, 32'd7, 32'hFFFFFFFD, 1'b0);
    issue(3'd1, MIN_NEG, MIN_NEG, 1'b1);
    issue(3'd3, '1, '1, 1'b1);
    issue(3'd2, '1, '1, 1'b0);
    idle(2);
    issue(3'd4, 32'hFFFFFFF9, 32'd2, 1'b0);
    issue(3'd6, 32'hFFFFFFF9, 32'd2, 1'b0);
    issue(3'd5, 32'd100, 32'd7, 1'b0);
    issue(3'd4, 32'd5, 32'd0, 1'b0);
    issue(3'd7, 32'd5, 32'd0, 1'b1);
    issue(3'd5, 32'd100, 32'd7, 1'b0);   // div_by_zero must clear on acceptance
    issue(3'd4, MIN_NEG, '1, 1'b0);
    issue(3'd6, MIN_NEG, '1, 1'b0);
    idle(1);

    // Flush in cycle 10 of a DIV.
    abort_op(3'd4, 32'hFFFFFFF9, 32'd2, 10, 1'b0);
    idle(2);
    // Flush together with valid in IDLE: not accepted.
    valid = 1'b1; flush = 1'b1; op = 3'd5; rs1 = 32'd9; rs2 = 32'd3;
    idle(1);
    valid = 1'b0; flush = 1'b0;
    idle(2);
    // Reset pulse in the middle of a MUL.
    abort_op(3'd0, 32'd7, 32'hFFFFFFFD, 5, 1'b1);
    idle(2);

    // Random requests.
    for (int n = 0; n < 1200; n++) begin
      o = 3'($urandom);
      a = rnd_opnd();
      b = rnd_opnd();
      gap = ($urandom_range(0, 7) == 0);
      issue(o, a, b, !gap);
      if (gap) idle($urandom_range(1, 3));
    end
    valid = 1'b0;
    exp_active = 1'b0;
    idle(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
